uart_baud_gen: RTL and testbench
================================

Name: uart_baud_gen

Overview:
Parametrised baud-tick generator for the UART TX/RX paths. It replaces the fixed half-baud overflow counter with one engine that has a run-time divisor and produces both mid-bit (half) and end-of-bit (full) ticks. It also tracks the bit index within a frame and flags frame completion. RX uses half_tick to sample at bit centre; TX uses full_tick to shift.

Parameters:
CNT_W, 16, width of the divisor and of the internal cycle counter
BIT_W, 4, width of frame_bits and bit_idx
AUTO_STOP, 1, 1: generator stops (busy=0) after frame_done; 0: free-runs into the next frame
MIN_DIV, 2, smallest legal divisor; smaller values are clamped to it

Ports:
clk  input  1  system clock
rst  input  1  reset: synchronous, active-high
enb  input  1  run enable; 0 pauses the counters (state held)
clear  input  1  start/resync pulse; zeroes counters, latches divisor and frame_bits, sets busy
divisor  input  CNT_W  clk cycles per bit period; sampled only on clear
frame_bits  input  BIT_W  bit periods per frame (e.g. 10 = start+8+stop); sampled only on clear; 0 is treated as 1
half_tick  output  1  one-cycle pulse at mid-bit
full_tick  output  1  one-cycle pulse at end of bit period
bit_idx  output  BIT_W  index of the current bit period, 0..frame_bits-1
frame_done  output  1  one-cycle pulse coincident with full_tick of the last bit
busy  output  1  generator armed/running

Behaviour:
- Reset (synchronous, active-high, highest priority): cnt=0, bit_idx=0, busy=0, div_q=MIN_DIV, nbits_q=1. All tick outputs are 0 in the cycle after reset.
- Priority at each clk edge: rst > clear > (busy & enb) count > hold.
- On clear:
  - cnt=0, bit_idx=0, busy=1.
  - div_q = max(divisor, MIN_DIV).
  - nbits_q = max(frame_bits, 1).
  - No tick is produced in a cycle where clear is high, even if the decode matches.
- Counting (busy & enb):
  - cnt increments each cycle.
  - When cnt == div_q-1, cnt wraps to 0.
  - When enb=0, cnt and bit_idx hold. This is a pause, not a reset.
- Tick decode is combinational from registered state, gated by busy & enb & !clear & !rst:
  - half_tick = (cnt == (div_q>>1)-1).
  - full_tick = (cnt == div_q-1).
  - Example div_q=16: half at cnt 7, full at cnt 15.
  - Example div_q=3: half at cnt 0, full at cnt 2.
  - Example div_q=2: half at cnt 0, full at cnt 1. Half and full never coincide for div_q >= 2.
- Bit index: on full_tick, bit_idx increments.
- End of frame: full_tick while bit_idx == nbits_q-1 asserts frame_done in the same cycle, and bit_idx returns to 0.
  - AUTO_STOP=1: busy clears at that edge; ticks stay 0 until the next clear.
  - AUTO_STOP=0: busy stays 1 and the next frame starts immediately.
- Divisor or frame_bits changes while busy have no effect until the next clear.
- clear while busy mid-frame: restart from cnt=0, bit_idx=0 with the newly sampled values. No frame_done is issued for the aborted frame.
- rst mid-frame: everything returns to reset values at that edge.
- Width rules:
  - cnt is CNT_W bits and never exceeds div_q-1.
  - For divisor = 2^CNT_W-1, the full period must be reached with no overflow.
  - half point uses a logical right shift; no rounding.
- Latency: with clear at edge 0 and enb held high, cnt=k during cycle k (k = 1, 2, …).
  - First half_tick in cycle (div>>1)-1.
  - First full_tick in cycle div-1.

Test Plan:
- rst=1 for 2 cycles, enb=1, no clear -> busy=0, bit_idx=0, no ticks for 50 cycles.
- divisor=16, frame_bits=10, AUTO_STOP=1, clear pulse, enb=1 -> half_tick at cycles 7,23,…,151; full_tick at 15,31,…,159; frame_done at 159 with bit_idx=9; busy=0 from cycle 160; no further ticks.
- divisor=16, clear, enb dropped for 5 cycles starting at cnt=4 -> cnt holds at 4; first full_tick delayed to cycle 20; half_tick at cycle 12.
- divisor=1 and divisor=3 -> clamped div_q=2 (half cnt 0, full cnt 1, alternating ticks); div 3: half cnt 0, full cnt 2.
- AUTO_STOP=0, frame_bits=2, divisor=4 -> frame_done every 8 cycles; busy stays 1; bit_idx sequence 0,1,0,1…
- Mid-frame clear at bit_idx=3 with divisor changed 16->8 -> no frame_done; restart with full_tick 7 cycles later. Then assert rst mid-frame -> all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Baud-tick engine shared by the UART TX and RX paths. It divides clk by a
// run-time divisor and produces two pulses per bit period:
//   half_tick - mid-bit, used by RX to sample at bit centre
//   full_tick - end of bit, used by TX to shift the next bit out
// It also tracks which bit period of the frame is active and flags the end
// of the frame.
//
// Parameters
//   CNT_W     width of divisor and of the internal cycle counter
//   BIT_W     width of frame_bits and bit_idx
//   AUTO_STOP 1: disarm after frame_done, 0: roll straight into the next frame
//   MIN_DIV   smallest usable divisor; smaller requests are raised to it
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   enb        run enable; low pauses the counters with state held
//   clear      start/resync; zeroes counters, latches divisor/frame_bits, arms
//   divisor    clk cycles per bit period (sampled on clear only)
//   frame_bits bit periods per frame (sampled on clear only; 0 acts as 1)
//   half_tick  one-cycle mid-bit pulse
//   full_tick  one-cycle end-of-bit pulse
//   bit_idx    current bit period, 0..frame_bits-1
//   frame_done one-cycle pulse alongside full_tick of the last bit
//   busy       generator armed/running
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CNT_W     = 16,
  parameter int BIT_W     = 4,
  parameter bit AUTO_STOP = 1'b1,
  parameter int MIN_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             clear,
  input  logic [CNT_W-1:0] divisor,
  input  logic [BIT_W-1:0] frame_bits,
  output logic             half_tick,
  output logic             full_tick,
  output logic [BIT_W-1:0] bit_idx,
  output logic             frame_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MIN_DIV_C = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic             busy_q,    busy_d;
  logic [CNT_W-1:0] div_q,     div_d;
  logic [BIT_W-1:0] nbits_q,   nbits_d;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] full_pt;   // last count of a bit period
  logic [CNT_W-1:0] half_pt;   // mid-bit count, truncating shift
  logic             run;       // counters may advance and ticks may fire
  logic             at_full;
  logic             at_half;
  logic             last_bit;

  // div_q never drops below MIN_DIV (>= 2), so both subtractions stay
  // non-negative and the full point of an all-ones divisor still fits in
  // CNT_W bits without wrapping.
  assign full_pt = div_q - CNT_ONE;
  assign half_pt = (div_q >> 1) - CNT_ONE;

  // Ticks are suppressed in a clear or reset cycle even when the count
  // matches, so a resync never leaks a stale pulse from the old period.
  assign run      = busy_q & enb & ~clear & ~rst;
  assign at_full  = (cnt_q == full_pt);
  assign at_half  = (cnt_q == half_pt);
  assign last_bit = (bit_idx_q == (nbits_q - BIT_ONE));

  assign half_tick  = run & at_half;
  assign full_tick  = run & at_full;
  assign frame_done = full_tick & last_bit;
  assign bit_idx    = bit_idx_q;
  assign busy       = busy_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the
    // branches below leaves a signal unassigned (which would infer a latch).
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    busy_d    = busy_q;
    div_d     = div_q;
    nbits_d   = nbits_q;

    if (clear) begin
      // Start or resync: configuration is captured here and only here, so
      // divisor/frame_bits may change freely while a frame is in flight.
      cnt_d     = '0;
      bit_idx_d = '0;
      busy_d    = 1'b1;
      div_d     = (divisor < MIN_DIV_C) ? MIN_DIV_C : divisor;
      nbits_d   = (frame_bits == '0) ? BIT_ONE : frame_bits;
    end else if (busy_q && enb) begin
      if (at_full) begin
        cnt_d = '0;
        if (last_bit) begin
          bit_idx_d = '0;
          if (AUTO_STOP) begin
            busy_d = 1'b0;
          end
        end else begin
          bit_idx_d = bit_idx_q + BIT_ONE;
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    // enb low (or idle): everything holds; a pause is not a restart.
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      // Idle divisor is the smallest legal one rather than zero so the
      // decode arithmetic never sees an out-of-range value.
      div_q     <= MIN_DIV_C;
      nbits_q   <= BIT_ONE;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      busy_q    <= busy_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Directed bench for uart_baud_gen. Two instances share the inputs: u_stop
// (AUTO_STOP=1) and u_free (AUTO_STOP=0). Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. "Cycle k" is the clock period
// that follows the k-th rising edge after the edge that captured clear.
// Each sample packs {busy, frame_done, full_tick, half_tick, bit_idx}.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

  localparam int CNT_W = 16;
  localparam int BIT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enb;
  logic             clear;
  logic [CNT_W-1:0] divisor;
  logic [BIT_W-1:0] frame_bits;

  logic             s_half, s_full, s_done, s_busy;
  logic [BIT_W-1:0] s_idx;
  logic             f_half, f_full, f_done, f_busy;
  logic [BIT_W-1:0] f_idx;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_baud_gen #(.CNT_W(CNT_W), .BIT_W(BIT_W), .AUTO_STOP(1'b1), .MIN_DIV(2)) u_stop (
    .clk(clk), .rst(rst), .enb(enb), .clear(clear),
    .divisor(divisor), .frame_bits(frame_bits),
    .half_tick(s_half), .full_tick(s_full), .bit_idx(s_idx),
    .frame_done(s_done), .busy(s_busy)
  );

  uart_baud_gen #(.CNT_W(CNT_W), .BIT_W(BIT_W), .AUTO_STOP(1'b0), .MIN_DIV(2)) u_free (
    .clk(clk), .rst(rst), .enb(enb), .clear(clear),
    .divisor(divisor), .frame_bits(frame_bits),
    .half_tick(f_half), .full_tick(f_full), .bit_idx(f_idx),
    .frame_done(f_done), .busy(f_busy)
  );

  function automatic logic [7:0] pack(bit b, bit d, bit f, bit h, int idx);
    return {b, d, f, h, 4'(idx)};
  endfunction

  task automatic check(string tag, int k, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: observed b/d/f/h/idx=%b expected %b", tag, k, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture clear at the next edge; returns 1 ns into cycle 0.
  task automatic do_clear(logic [CNT_W-1:0] div, logic [BIT_W-1:0] fb);
    divisor    = div;
    frame_bits = fb;
    clear      = 1'b1;
    step();
    clear      = 1'b0;
  endtask

  function automatic logic [7:0] obs_stop();
    return {s_busy, s_done, s_full, s_half, s_idx};
  endfunction

  function automatic logic [7:0] obs_free();
    return {f_busy, f_done, f_full, f_half, f_idx};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    enb        = 1'b1;
    clear      = 1'b0;
    divisor    = 16'd16;
    frame_bits = 4'd10;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1) Out of reset, enabled, never cleared: idle and silent.
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("idle_stop", k, obs_stop(), 8'h00);
      if (k == 0) check("idle_free", k, obs_free(), 8'h00);
      step();
    end

    // 2) divisor 16, 10-bit frame, auto-stop: half at 7+16n, full at 15+16n,
    //    frame_done at 159 with bit_idx 9, then idle.
    do_clear(16'd16, 4'd10);
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      if (k < 160)
        check("frame16", k, obs_stop(),
              pack(1'b1, k == 159, (k % 16) == 15, (k % 16) == 7, k / 16));
      else
        check("frame16_idle", k, obs_stop(), 8'h00);
      step();
    end

    // 3) Pause: enb low during cycles 4..8 holds cnt at 4; half moves to
    //    cycle 12, full to cycle 20.
    do_clear(16'd16, 4'd10);
    for (int k = 0; k < 25; k++) begin
      enb = !(k >= 4 && k <= 8);
      @(negedge clk);
      check("pause", k, obs_stop(), pack(1'b1, 1'b0, k == 20, k == 12, (k > 20) ? 1 : 0));
      step();
    end
    enb = 1'b1;

    // 4a) divisor 1 clamps to 2: half on even cycles, full on odd; 3-bit frame
    //     ends at cycle 5.
    do_clear(16'd1, 4'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6)
        check("div1", k, obs_stop(), pack(1'b1, k == 5, (k % 2) == 1, (k % 2) == 0, k / 2));
      else
        check("div1_idle", k, obs_stop(), 8'h00);
      step();
    end

    // 4b) divisor 3, frame_bits 0 treated as 1: half cycle 0, full+done cycle 2.
    do_clear(16'd3, 4'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3)
        check("div3", k, obs_stop(), pack(1'b1, k == 2, k == 2, k == 0, 0));
      else
        check("div3_idle", k, obs_stop(), 8'h00);
      step();
    end

    // 5) Free-running instance: divisor 4, 2-bit frame -> done every 8 cycles,
    //    bit_idx 0,1,0,1..., busy held.
    do_clear(16'd4, 4'd2);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check("free", k, obs_free(),
            pack(1'b1, (k % 8) == 7, (k % 4) == 3, (k % 4) == 1, (k / 4) % 2));
      step();
    end

    // 6) Mid-frame resync. Run divisor 16 to cycle 63 (bit_idx 3, at the full
    //    point); clear there with divisor 8. No tick or done in the clear cycle.
    do_clear(16'd16, 4'd10);
    for (int k = 0; k < 63; k++) step();
    divisor    = 16'd8;
    frame_bits = 4'd10;
    clear      = 1'b1;
    @(negedge clk);
    check("clear_cycle", 63, obs_stop(), pack(1'b1, 1'b0, 1'b0, 1'b0, 3));
    step();
    clear   = 1'b0;
    divisor = 16'd3;  // must be ignored until the next clear
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("resync8", k, obs_stop(), pack(1'b1, 1'b0, k == 7, k == 3, (k > 7) ? 1 : 0));
      step();
    end

    // Reset mid-frame: both instances return to idle and stay there.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_stop", k, obs_stop(), 8'h00);
      check("rst_free", k, obs_free(), 8'h00);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
